// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter and sequencer for a shared external combinational ALU.
// Operands are registered onto the ALU, the result is captured one cycle later and held until accepted.
//
// state | meaning
// IDLE  | arbitrating; a requester may hand over an operation
// EXEC  | operands on alu_*; alu_y is captured into rsp_y at the end of this cycle
// RESP  | result held on rsp_y for the owner until its rsp_ready
module alu_share_arbiter #(
    parameter int W  = 4,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [SW-1:0] req0_s,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [SW-1:0] req1_s,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [W-1:0]  rsp_y,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [SW-1:0] alu_s,
    input  logic [W-1:0]  alu_y,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   prio;
    logic   owner;
    logic   grant0, grant1;
    logic   handshake;

    // On a tie the pointer picks; a lone valid always wins.
    assign grant0    = req0_valid && (!req1_valid || !prio);
    assign grant1    = req1_valid && (!req0_valid ||  prio);
    assign handshake = req0_ready || req1_ready;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = rst_n && grant0;
                req1_ready = rst_n && grant1;
                if (req0_ready || req1_ready) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if ((!owner && rsp0_ready) || (owner && rsp1_ready)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            alu_a <= '0;
            alu_b <= '0;
            alu_s <= '0;
            rsp_y <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                owner <= req1_ready;
                prio  <= ~req1_ready;
                alu_a <= req1_ready ? req1_a : req0_a;
                alu_b <= req1_ready ? req1_b : req0_b;
                alu_s <= req1_ready ? req1_s : req0_s;
            end
            if (state == EXEC) rsp_y <= alu_y;
        end
    end

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) &&  owner;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a reference combinational ALU model attached.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req0_s, req1_a, req1_b, req1_s;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [3:0] rsp_y, alu_a, alu_b, alu_s, alu_y;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] s);
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~a;
            4'd6:  return a << 1;
            4'd7:  return a >> 1;
            4'd8:  return a + 4'd1;
            4'd9:  return a - 4'd1;
            4'd10: return ~(a & b);
            4'd11: return ~(a | b);
            4'd12: return b;
            4'd13: return a;
            4'd14: return a * b;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_y = alu_model(alu_a, alu_b, alu_s);

    alu_share_arbiter #(.W(4), .SW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_y(alu_y), .busy(busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed results for a=12, b=2 and opcodes 0..15.
    logic [3:0] sweep_exp [16] = '{4'd14, 4'd10, 4'd0, 4'd14, 4'd14, 4'd3, 4'd8, 4'd6,
                                   4'd13, 4'd11, 4'd15, 4'd1, 4'd2, 4'd12, 4'd8, 4'd0};
    logic       cont_grant [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] cont_y     [4] = '{4'd4, 4'd7, 4'd4, 4'd7};

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'd5; req0_b = 4'd6; req0_s = 4'd3;
        req1_a = 4'd7; req1_b = 4'd1; req1_s = 4'd4;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset with both valids high
        tick();
        tick();
        chk("rst_req0_ready", {7'd0, req0_ready}, 8'd0);
        chk("rst_req1_ready", {7'd0, req1_ready}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'd0);
        chk("rst_alu", {alu_a, alu_b}, 8'd0);
        chk("rst_alu_s", {4'd0, alu_s}, 8'd0);
        chk("rst_rsp_y", {4'd0, rsp_y}, 8'd0);

        // Release: tie goes to req0 first
        rst_n = 1'b1;
        req0_a = 4'd12; req0_b = 4'd2; req0_s = 4'd0;
        #1;
        chk("first_tie_req0", {6'd0, req1_ready, req0_ready}, 8'b01);
        req1_valid = 1'b0;
        #1;
        chk("single_ready", {6'd0, req1_ready, req0_ready}, 8'b01);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("single_alu_ops", {alu_a, alu_b}, {4'd12, 4'd2});
        chk("single_alu_s", {4'd0, alu_s}, 8'd0);
        chk("single_exec_busy", {6'd0, busy, rsp0_valid}, 8'b10);
        tick();
        chk("single_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'b01);
        chk("single_rsp_y", {4'd0, rsp_y}, 8'd14);
        rsp0_ready = 1'b1;
        tick();
        chk("single_idle", {5'd0, busy, rsp1_valid, rsp0_valid}, 8'd0);

        // Contention: prio now points at req1
        req0_a = 4'd3; req0_b = 4'd4; req0_s = 4'd0;
        req1_a = 4'd9; req1_b = 4'd5; req1_s = 4'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_grant_%0d", i), {6'd0, req1_ready, req0_ready},
                cont_grant[i] ? 8'b10 : 8'b01);
            tick();
            chk($sformatf("cont_exec_ready_%0d", i), {6'd0, req1_ready, req0_ready}, 8'd0);
            tick();
            chk($sformatf("cont_rsp_valid_%0d", i), {6'd0, rsp1_valid, rsp0_valid},
                cont_grant[i] ? 8'b10 : 8'b01);
            chk($sformatf("cont_rsp_y_%0d", i), {4'd0, rsp_y}, {4'd0, cont_y[i]});
            tick();
        end

        // Backpressure on req1's response
        req0_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req1_a = 4'd12; req1_b = 4'd2; req1_s = 4'd1;
        #1;
        chk("bp_grant", {6'd0, req1_ready, req0_ready}, 8'b10);
        tick();
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b1;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_hold_%0d", i), {rsp1_valid, rsp0_valid, busy, req0_ready, rsp_y},
                {4'b1010, 4'd10});
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_release_cycle", {6'd0, rsp1_valid, busy}, 8'b11);
        tick();
        chk("bp_idle", {5'd0, busy, rsp1_valid, req0_ready}, 8'b001);
        req0_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset mid-operation: req0 alone moves prio to req1, then abort in EXEC
        req0_a = 4'd1; req0_b = 4'd1; req0_s = 4'd0;
        req0_valid = 1'b1;
        #1;
        chk("mid_grant", {6'd0, req1_ready, req0_ready}, 8'b01);
        tick();
        req0_valid = 1'b0;
        chk("mid_in_exec", {6'd0, busy, rsp0_valid}, 8'b10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("mid_idle", {5'd0, busy, rsp1_valid, rsp0_valid}, 8'd0);
        chk("mid_rsp_y", {4'd0, rsp_y}, 8'd0);
        chk("mid_alu_a", {4'd0, alu_a}, 8'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_tie_req0", {6'd0, req1_ready, req0_ready}, 8'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid_no_rsp_%0d", i), {6'd0, rsp1_valid, rsp0_valid}, 8'd0);
        end

        // Opcode sweep from req1
        req1_a = 4'd12; req1_b = 4'd2;
        req1_valid = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req1_s = 4'(i);
            #1;
            chk($sformatf("sweep_grant_%0d", i), {6'd0, req1_ready, req0_ready}, 8'b10);
            tick();
            chk($sformatf("sweep_alu_s_%0d", i), {4'd0, alu_s}, 8'(i));
            tick();
            chk($sformatf("sweep_rsp_%0d", i), {3'd0, rsp1_valid, rsp_y},
                {4'b0001, sweep_exp[i]});
            tick();
        end
        req1_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
